rom_dl_packer: RTL and testbench

- Sits between data_io and the sdram controller in the arcade top level.
- Consumes the ioctl byte stream (ioctl_wr strobes) during ROM download and packs byte pairs into 16-bit words.
- Routes each word by address region:
  - CPU region -> sdram port1
  - sound region -> sdram port2, address rebased to 0
  - all other bytes -> internal game download bus, passed straight through
- Runs the toggle req/ack handshake per word, buffers words in a small FIFO, and asserts rom_loaded once the last word has been acknowledged.

---
 rtl/rom_dl_packer.sv | 298 +++++++++++++++++++++++++++++
 tb/tb_rom_dl_packer.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_dl_packer.sv
// rom_dl_packer: packs the ioctl ROM download byte stream into 16-bit SDRAM
// words, routes them by address region and drives the toggle req/ack handshake.
//
// state  | meaning
// S_IDLE | no request outstanding; issue the FIFO head if one is queued
// S_WAIT | selected port's req toggled; waiting for its ack to match
module rom_dl_packer #(
  parameter logic [24:0] CPU_END    = 25'h08000,
  parameter logic [24:0] SND_END    = 25'h0A000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ioctl_downl,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        p1_req,
  input  logic        p1_ack,
  output logic [22:0] p1_a,
  output logic [15:0] p1_d,
  output logic [1:0]  p1_ds,
  output logic        p1_we,
  output logic        p2_req,
  input  logic        p2_ack,
  output logic [22:0] p2_a,
  output logic [15:0] p2_d,
  output logic [1:0]  p2_ds,
  output logic        p2_we,
  output logic [16:0] gfx_addr,
  output logic [7:0]  gfx_data,
  output logic        gfx_wr,
  output logic        rom_loaded,
  output logic        busy,
  output logic        overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef struct packed {
    logic        rgn;   // 0 = port1 (CPU), 1 = port2 (sound)
    logic [22:0] a;
    logic [15:0] d;
    logic [1:0]  ds;
  } word_t;

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  function automatic word_t mk_word(input logic rgn, input logic [24:0] addr,
                                    input logic [15:0] d, input logic [1:0] ds);
    word_t w;
    w.rgn = rgn;
    w.a   = 23'((addr - (rgn ? CPU_END : 25'd0)) >> 1);
    w.d   = d;
    w.ds  = ds;
    return w;
  endfunction

  logic        wr_d_q, wr_d_d;
  logic        downl_d_q, downl_d_d;
  logic        fell_seen_q, fell_seen_d;
  logic        pair_vld_q, pair_vld_d;
  logic [24:0] pair_addr_q, pair_addr_d;
  logic [7:0]  pair_byte_q, pair_byte_d;
  logic        pair_rgn_q, pair_rgn_d;
  logic        pend_vld_q, pend_vld_d;
  word_t       pend_word_q, pend_word_d;
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  word_t       mem_q [FIFO_DEPTH];
  state_t      state_q, state_d;
  logic        sel_q, sel_d;
  logic        p1_req_q, p1_req_d, p1_we_q, p1_we_d;
  logic [22:0] p1_a_q, p1_a_d;
  logic [15:0] p1_d_q, p1_d_d;
  logic [1:0]  p1_ds_q, p1_ds_d;
  logic        p2_req_q, p2_req_d, p2_we_q, p2_we_d;
  logic [22:0] p2_a_q, p2_a_d;
  logic [15:0] p2_d_q, p2_d_d;
  logic [1:0]  p2_ds_q, p2_ds_d;
  logic [16:0] gfx_addr_q, gfx_addr_d;
  logic [7:0]  gfx_data_q, gfx_data_d;
  logic        gfx_wr_q, gfx_wr_d;
  logic        rom_loaded_q, rom_loaded_d;
  logic        busy_q, busy_d;
  logic        ovf_q, ovf_d;

  logic        wr_edge, is_p1, is_p2, is_gfx, downl_rise, downl_fall;
  logic        push, push_ok, pop, empty, full;
  word_t       push_word, held_word, odd_word, head;

  assign head = mem_q[rd_ptr_q[AW-1:0]];

  // Byte intake: edge detect, region decode, pairing and passthrough
  always_comb begin
    wr_d_d     = ioctl_wr;
    downl_d_d  = ioctl_downl;
    downl_rise = ioctl_downl & ~downl_d_q;
    downl_fall = ~ioctl_downl & downl_d_q;
    wr_edge    = ioctl_downl & ioctl_wr & ~wr_d_q;
    is_p1      = ioctl_addr < CPU_END;
    is_p2      = !is_p1 && (ioctl_addr < SND_END);
    is_gfx     = !is_p1 && !is_p2;

    held_word  = mk_word(pair_rgn_q, pair_addr_q, {pair_byte_q, pair_byte_q},
                         pair_addr_q[0] ? 2'b10 : 2'b01);
    odd_word   = mk_word(is_p2, ioctl_addr, {ioctl_dout, ioctl_dout}, 2'b10);

    pair_vld_d  = pair_vld_q;
    pair_addr_d = pair_addr_q;
    pair_byte_d = pair_byte_q;
    pair_rgn_d  = pair_rgn_q;
    pend_vld_d  = 1'b0;
    pend_word_d = pend_word_q;
    push        = 1'b0;
    push_word   = held_word;

    if (pend_vld_q) begin
      push      = 1'b1;
      push_word = pend_word_q;
    end else if (wr_edge && !is_gfx) begin
      if (!ioctl_addr[0]) begin
        push        = pair_vld_q;
        pair_vld_d  = 1'b1;
        pair_addr_d = ioctl_addr;
        pair_byte_d = ioctl_dout;
        pair_rgn_d  = is_p2;
      end else if (pair_vld_q && (ioctl_addr == pair_addr_q + 25'd1)) begin
        push       = 1'b1;
        push_word  = mk_word(pair_rgn_q, pair_addr_q, {ioctl_dout, pair_byte_q}, 2'b11);
        pair_vld_d = 1'b0;
      end else if (pair_vld_q) begin
        // Orphan odd byte behind a held byte: flush now, odd byte next cycle
        push        = 1'b1;
        pend_vld_d  = 1'b1;
        pend_word_d = odd_word;
        pair_vld_d  = 1'b0;
      end else begin
        push      = 1'b1;
        push_word = odd_word;
      end
    end else if (!ioctl_downl && fell_seen_q && pair_vld_q) begin
      push       = 1'b1;
      pair_vld_d = 1'b0;
    end

    gfx_wr_d   = wr_edge & is_gfx;
    gfx_addr_d = gfx_wr_d ? ioctl_addr[16:0] : gfx_addr_q;
    gfx_data_d = gfx_wr_d ? ioctl_dout : gfx_data_q;
  end

  // Issue FSM; the head is popped at issue and the port registers hold the
  // in-flight word until its ack matches.
  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    pop      = 1'b0;
    p1_req_d = p1_req_q;
    p1_we_d  = p1_we_q;
    p1_a_d   = p1_a_q;
    p1_d_d   = p1_d_q;
    p1_ds_d  = p1_ds_q;
    p2_req_d = p2_req_q;
    p2_we_d  = p2_we_q;
    p2_a_d   = p2_a_q;
    p2_d_d   = p2_d_q;
    p2_ds_d  = p2_ds_q;
    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          sel_d   = head.rgn;
          state_d = S_WAIT;
          if (head.rgn) begin
            p2_a_d   = head.a;
            p2_d_d   = head.d;
            p2_ds_d  = head.ds;
            p2_we_d  = 1'b1;
            p2_req_d = ~p2_req_q;
          end else begin
            p1_a_d   = head.a;
            p1_d_d   = head.d;
            p1_ds_d  = head.ds;
            p1_we_d  = 1'b1;
            p1_req_d = ~p1_req_q;
          end
        end
      end
      S_WAIT: begin
        if (sel_q ? (p2_ack == p2_req_q) : (p1_ack == p1_req_q)) begin
          p1_we_d = 1'b0;
          p2_we_d = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    empty    = (wr_ptr_q == rd_ptr_q);
    full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    push_ok  = push && (!full || pop);
    wr_ptr_d = push_ok ? wr_ptr_q + (AW+1)'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + (AW+1)'(1) : rd_ptr_q;
    ovf_d    = ovf_q | (push & full & ~pop);

    fell_seen_d  = downl_rise ? 1'b0 : (downl_fall ? 1'b1 : fell_seen_q);
    rom_loaded_d = downl_rise ? 1'b0 :
                   (rom_loaded_q | (!ioctl_downl && fell_seen_q && empty &&
                                    state_q == S_IDLE && !pair_vld_q && !pend_vld_q));
    busy_d       = ioctl_downl | !empty | (state_q != S_IDLE) | pair_vld_q | pend_vld_q;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      wr_d_q       <= 1'b0;
      downl_d_q    <= 1'b0;
      fell_seen_q  <= 1'b0;
      pair_vld_q   <= 1'b0;
      pair_addr_q  <= '0;
      pair_byte_q  <= '0;
      pair_rgn_q   <= 1'b0;
      pend_vld_q   <= 1'b0;
      pend_word_q  <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      state_q      <= S_IDLE;
      sel_q        <= 1'b0;
      p1_req_q     <= 1'b0;
      p1_we_q      <= 1'b0;
      p1_a_q       <= '0;
      p1_d_q       <= '0;
      p1_ds_q      <= '0;
      p2_req_q     <= 1'b0;
      p2_we_q      <= 1'b0;
      p2_a_q       <= '0;
      p2_d_q       <= '0;
      p2_ds_q      <= '0;
      gfx_addr_q   <= '0;
      gfx_data_q   <= '0;
      gfx_wr_q     <= 1'b0;
      rom_loaded_q <= 1'b0;
      busy_q       <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      wr_d_q       <= wr_d_d;
      downl_d_q    <= downl_d_d;
      fell_seen_q  <= fell_seen_d;
      pair_vld_q   <= pair_vld_d;
      pair_addr_q  <= pair_addr_d;
      pair_byte_q  <= pair_byte_d;
      pair_rgn_q   <= pair_rgn_d;
      pend_vld_q   <= pend_vld_d;
      pend_word_q  <= pend_word_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= push_word;
      state_q      <= state_d;
      sel_q        <= sel_d;
      p1_req_q     <= p1_req_d;
      p1_we_q      <= p1_we_d;
      p1_a_q       <= p1_a_d;
      p1_d_q       <= p1_d_d;
      p1_ds_q      <= p1_ds_d;
      p2_req_q     <= p2_req_d;
      p2_we_q      <= p2_we_d;
      p2_a_q       <= p2_a_d;
      p2_d_q       <= p2_d_d;
      p2_ds_q      <= p2_ds_d;
      gfx_addr_q   <= gfx_addr_d;
      gfx_data_q   <= gfx_data_d;
      gfx_wr_q     <= gfx_wr_d;
      rom_loaded_q <= rom_loaded_d;
      busy_q       <= busy_d;
      ovf_q        <= ovf_d;
    end
  end

  assign p1_req     = p1_req_q;
  assign p1_a       = p1_a_q;
  assign p1_d       = p1_d_q;
  assign p1_ds      = p1_ds_q;
  assign p1_we      = p1_we_q;
  assign p2_req     = p2_req_q;
  assign p2_a       = p2_a_q;
  assign p2_d       = p2_d_q;
  assign p2_ds      = p2_ds_q;
  assign p2_we      = p2_we_q;
  assign gfx_addr   = gfx_addr_q;
  assign gfx_data   = gfx_data_q;
  assign gfx_wr     = gfx_wr_q;
  assign rom_loaded = rom_loaded_q;
  assign busy       = busy_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_rom_dl_packer.sv
// Self-checking bench for rom_dl_packer: a byte-level packing model feeds
// expected-word queues that a per-cycle monitor checks against the ports.
module tb_rom_dl_packer;

  localparam int ACK_DLY = 5;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic        ioctl_downl, ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        p1_req, p1_ack, p1_we, p2_req, p2_ack, p2_we;
  logic [22:0] p1_a, p2_a;
  logic [15:0] p1_d, p2_d;
  logic [1:0]  p1_ds, p2_ds;
  logic [16:0] gfx_addr;
  logic [7:0]  gfx_data;
  logic        gfx_wr, rom_loaded, busy, overflow;

  rom_dl_packer dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .ioctl_downl(ioctl_downl),
    .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .p1_req(p1_req), .p1_ack(p1_ack), .p1_a(p1_a), .p1_d(p1_d), .p1_ds(p1_ds), .p1_we(p1_we),
    .p2_req(p2_req), .p2_ack(p2_ack), .p2_a(p2_a), .p2_d(p2_d), .p2_ds(p2_ds), .p2_we(p2_we),
    .gfx_addr(gfx_addr), .gfx_data(gfx_data), .gfx_wr(gfx_wr),
    .rom_loaded(rom_loaded), .busy(busy), .overflow(overflow)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct packed {
    logic [22:0] a;
    logic [15:0] d;
    logic [1:0]  ds;
  } exp_t;

  exp_t        exp_p1[$];
  exp_t        exp_p2[$];
  logic [24:0] exp_gfx[$];

  int tests = 0;
  int fails = 0;

  logic        m_vld = 1'b0;
  logic [24:0] m_addr;
  logic [7:0]  m_dat;

  logic        chk_en = 1'b0;
  logic [1:0]  hold = 2'b00;
  logic        req_prev [2];
  logic        match_seen [2];
  int          issues [2];
  logic [40:0] cur [2];
  logic        gfx_prev = 1'b0;
  int          gfx_cnt = 0;
  logic [16:0] last_gfx_addr;
  logic [7:0]  last_gfx_data;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Expected SDRAM words straight from the byte-level rules
  task automatic model_emit(input logic [24:0] addr, input logic [15:0] d, input logic [1:0] ds);
    exp_t e;
    e.d  = d;
    e.ds = ds;
    if (addr < 25'h08000) begin
      e.a = 23'(addr / 2);
      exp_p1.push_back(e);
    end else begin
      e.a = 23'((addr - 25'h08000) / 2);
      exp_p2.push_back(e);
    end
  endtask

  task automatic model_byte(input logic [24:0] a, input logic [7:0] b);
    if (a >= 25'h0A000) begin
      exp_gfx.push_back({a[16:0], b});
    end else if (a % 2 == 0) begin
      if (m_vld) model_emit(m_addr, {m_dat, m_dat}, 2'b01);
      m_vld  = 1'b1;
      m_addr = a;
      m_dat  = b;
    end else if (m_vld && m_addr + 25'd1 == a) begin
      model_emit(m_addr, {b, m_dat}, 2'b11);
      m_vld = 1'b0;
    end else begin
      if (m_vld) model_emit(m_addr, {m_dat, m_dat}, 2'b01);
      m_vld = 1'b0;
      model_emit(a, {b, b}, 2'b10);
    end
  endtask

  task automatic model_flush();
    if (m_vld) model_emit(m_addr, {m_dat, m_dat}, 2'b01);
    m_vld = 1'b0;
  endtask

  task automatic port_cycle(input int p, input logic req, input logic ack, input logic we,
                            input logic [22:0] a, input logic [15:0] d, input logic [1:0] ds);
    exp_t e;
    logic have;
    string pn;
    pn = (p == 0) ? "p1" : "p2";
    if (match_seen[p]) check({pn, "_we_drop"}, {63'd0, we}, 64'd0);
    if (req != req_prev[p]) begin
      issues[p]++;
      have = (p == 0) ? (exp_p1.size() > 0) : (exp_p2.size() > 0);
      if (!have) begin
        check({pn, "_unexpected_req"}, 64'd1, 64'd0);
      end else begin
        if (p == 0) e = exp_p1.pop_front();
        else        e = exp_p2.pop_front();
        check({pn, "_a"}, {41'd0, a}, {41'd0, e.a});
        check({pn, "_d"}, {48'd0, d}, {48'd0, e.d});
        check({pn, "_ds"}, {62'd0, ds}, {62'd0, e.ds});
        check({pn, "_we_issue"}, {63'd0, we}, 64'd1);
      end
      cur[p] = {a, d, ds};
    end else if (req != ack) begin
      check({pn, "_stable"}, {23'd0, a, d, ds}, {23'd0, cur[p]});
    end
    match_seen[p] = (req == ack) && we;
    req_prev[p]   = req;
  endtask

  always @(negedge clk_sys) begin
    if (chk_en) begin
      port_cycle(0, p1_req, p1_ack, p1_we, p1_a, p1_d, p1_ds);
      port_cycle(1, p2_req, p2_ack, p2_we, p2_a, p2_d, p2_ds);
      if (gfx_wr) begin
        logic [24:0] g;
        if (gfx_prev) check("gfx_wr_width", 64'd1, 64'd0);
        if (exp_gfx.size() == 0) begin
          check("gfx_unexpected", 64'd1, 64'd0);
        end else begin
          g = exp_gfx.pop_front();
          check("gfx_addr", {47'd0, gfx_addr}, {47'd0, g[24:8]});
          check("gfx_data", {56'd0, gfx_data}, {56'd0, g[7:0]});
          gfx_cnt++;
          last_gfx_addr = gfx_addr;
          last_gfx_data = gfx_data;
        end
      end
      gfx_prev = gfx_wr;
    end
  end

  // SDRAM stand-in: returns each toggle ACK_DLY cycles later unless held
  initial begin : responder
    int c1, c2;
    c1 = 0;
    c2 = 0;
    p1_ack = 1'b0;
    p2_ack = 1'b0;
    forever begin
      @(posedge clk_sys);
      #1;
      if (p1_req != p1_ack && !hold[0]) begin
        c1++;
        if (c1 >= ACK_DLY) begin p1_ack = p1_req; c1 = 0; end
      end else c1 = 0;
      if (p2_req != p2_ack && !hold[1]) begin
        c2++;
        if (c2 >= ACK_DLY) begin p2_ack = p2_req; c2 = 0; end
      end else c2 = 0;
    end
  end

  task automatic send(input logic [24:0] a, input logic [7:0] b);
    @(posedge clk_sys);
    #2;
    ioctl_addr = a;
    ioctl_dout = b;
    ioctl_wr   = 1'b1;
    model_byte(a, b);
    repeat (2) @(posedge clk_sys);
    #2;
    ioctl_wr = 1'b0;
    repeat (2) @(posedge clk_sys);
  endtask

  task automatic wait_drain(input string name);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(posedge clk_sys);
      #2;
      ok = (exp_p1.size() == 0) && (exp_p2.size() == 0) && (p1_req == p1_ack) &&
           (p2_req == p2_ack) && !p1_we && !p2_we;
    end
    check({name, "_drain"}, {63'd0, ok}, 64'd1);
  endtask

  task automatic wait_loaded(input string name);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(posedge clk_sys);
      #2;
      ok = rom_loaded;
    end
    check({name, "_rom_loaded"}, {63'd0, ok}, 64'd1);
    check({name, "_busy"}, {63'd0, busy}, 64'd0);
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int base;
    reset_n     = 1'b0;
    ioctl_downl = 1'b0;
    ioctl_wr    = 1'b1;
    ioctl_addr  = '0;
    ioctl_dout  = '0;
    req_prev[0] = 1'b0; req_prev[1] = 1'b0;
    match_seen[0] = 1'b0; match_seen[1] = 1'b0;
    issues[0] = 0; issues[1] = 0;
    cur[0] = '0; cur[1] = '0;

    repeat (3) @(posedge clk_sys);
    #2;
    check("reset_p1", {21'd0, p1_req, p1_a, p1_d, p1_ds, p1_we}, 64'd0);
    check("reset_p2", {21'd0, p2_req, p2_a, p2_d, p2_ds, p2_we}, 64'd0);
    check("reset_misc", {35'd0, gfx_addr, gfx_data, gfx_wr, rom_loaded, busy, overflow}, 64'd0);
    reset_n = 1'b1;
    chk_en  = 1'b1;
    repeat (5) @(posedge clk_sys);
    #2;
    check("post_reset_idle", {59'd0, p1_req, p2_req, busy, rom_loaded, overflow}, 64'd0);
    ioctl_wr    = 1'b0;
    ioctl_downl = 1'b1;
    repeat (2) @(posedge clk_sys);

    // CPU word pair
    send(25'h00000, 8'h12);
    send(25'h00001, 8'h34);
    wait_drain("p1_pair");
    check("p1_pair_a", {41'd0, p1_a}, 64'h0);
    check("p1_pair_d", {48'd0, p1_d}, 64'h3412);
    check("p1_pair_ds", {62'd0, p1_ds}, 64'h3);
    check("p1_pair_issues", issues[0], 1);

    // Sound word pair, rebased to 0
    send(25'h08000, 8'hAA);
    send(25'h08001, 8'hBB);
    wait_drain("p2_pair");
    check("p2_pair_a", {41'd0, p2_a}, 64'h0);
    check("p2_pair_d", {48'd0, p2_d}, 64'hBBAA);
    check("p2_pair_ds", {62'd0, p2_ds}, 64'h3);
    check("p2_pair_p1_untouched", issues[0], 1);
    check("p2_pair_issues", issues[1], 1);

    // Passthrough byte
    send(25'h0A003, 8'h55);
    repeat (4) @(posedge clk_sys);
    #2;
    check("gfx_count", gfx_cnt, 1);
    check("gfx_last_addr", {47'd0, last_gfx_addr}, 64'h0A003);
    check("gfx_last_data", {56'd0, last_gfx_data}, 64'h55);
    check("gfx_no_req", issues[0] + issues[1], 2);

    // Lone odd byte at the top of the sound region
    send(25'h09FFF, 8'hC3);
    wait_drain("p2_odd");
    check("p2_odd_a", {41'd0, p2_a}, 64'hFFF);
    check("p2_odd_d", {48'd0, p2_d}, 64'hC3C3);
    check("p2_odd_ds", {62'd0, p2_ds}, 64'h2);

    // Held even byte flushed by a non-matching odd byte
    send(25'h00020, 8'h20);
    send(25'h00023, 8'h21);
    wait_drain("p1_orphan");
    check("p1_orphan_issues", issues[0], 3);
    check("p1_orphan_a", {41'd0, p1_a}, 64'h11);
    check("p1_orphan_d", {48'd0, p1_d}, 64'h2121);
    check("p1_orphan_ds", {62'd0, p1_ds}, 64'h2);

    // Passthrough byte at SND_END between the halves of a pair
    send(25'h00030, 8'h40);
    send(25'h0A000, 8'h99);
    send(25'h00031, 8'h41);
    wait_drain("p1_split");
    check("p1_split_a", {41'd0, p1_a}, 64'h18);
    check("p1_split_d", {48'd0, p1_d}, 64'h4140);
    check("p1_split_ds", {62'd0, p1_ds}, 64'h3);
    check("p1_split_gfx", gfx_cnt, 2);

    // Held even byte flushed at end of download
    send(25'h00010, 8'h77);
    ioctl_downl = 1'b0;
    model_flush();
    wait_drain("end_flush");
    check("end_flush_a", {41'd0, p1_a}, 64'h8);
    check("end_flush_d", {48'd0, p1_d}, 64'h7777);
    check("end_flush_ds", {62'd0, p1_ds}, 64'h1);
    wait_loaded("end_flush");
    check("end_flush_overflow", {63'd0, overflow}, 64'd0);

    // Second download with acks held off: overflow
    @(posedge clk_sys);
    #2;
    ioctl_downl = 1'b1;
    repeat (2) @(posedge clk_sys);
    #2;
    check("redl_rom_loaded_clr", {63'd0, rom_loaded}, 64'd0);
    check("redl_busy", {63'd0, busy}, 64'd1);
    hold = 2'b01;
    base = issues[0];
    for (int i = 0; i < 6; i++) begin
      send(25'h00100 + 25'(2 * i), 8'h60 + 8'(i));
      send(25'h00101 + 25'(2 * i), 8'hA0 + 8'(i));
    end
    #2;
    check("ovf_set", {63'd0, overflow}, 64'd1);
    check("ovf_inflight", issues[0] - base, 1);
    // sixth word is the one that found the FIFO full
    check("ovf_queued", exp_p1.size(), 5);
    void'(exp_p1.pop_back());
    ioctl_downl = 1'b0;
    model_flush();
    repeat (6) @(posedge clk_sys);
    #2;
    check("ovf_not_loaded_while_held", {63'd0, rom_loaded}, 64'd0);
    hold = 2'b00;
    wait_drain("ovf");
    check("ovf_delivered", issues[0] - base, 5);
    check("ovf_last_a", {41'd0, p1_a}, 64'h84);
    check("ovf_last_d", {48'd0, p1_d}, 64'hA464);
    wait_loaded("ovf");
    check("ovf_sticky", {63'd0, overflow}, 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
